comparator_serial: RTL and testbench
====================================

COMPARATOR_SERIAL -- requirements
Module: comparator_serial

Interface
REQ-001 Parameter WIDTH, default 8: operand width in bits; SHALL be >= 2.
REQ-002 Parameter CHUNK, default 2: bits compared per cycle; SHALL divide WIDTH exactly; N = WIDTH/CHUNK.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 start  input  1  request to compare; accepted only when busy=0.
REQ-006 signed_mode  input  1  1 = two's-complement compare, 0 = unsigned; sampled on acceptance.
REQ-007 first_word  input  WIDTH  operand A; sampled on acceptance.
REQ-008 second_word  input  WIDTH  operand B; sampled on acceptance.
REQ-009 busy  output  1  high whenever the FSM is not IDLE.
REQ-010 done  output  1  one-cycle pulse: result valid.
REQ-011 eq  output  1  A == B.
REQ-012 lt  output  1  A < B.
REQ-013 gt  output  1  A > B.

Function
REQ-014 FSM states: IDLE, RUN, DONE; busy = (state != IDLE).
REQ-015 IDLE with start=1 at an edge: latch operands and signed_mode, clear eq/lt/gt, chunk index = 0, go to RUN.
REQ-016 Signed mode: invert the MSB of both latched operands at latch time; the unsigned compare of the biased values then gives the signed result.
REQ-017 RUN, each edge: compare the current MSB-first CHUNK of A and B as unsigned values.
REQ-018 Chunks differ: set lt or gt from that chunk, go to DONE (early termination).
REQ-019 Chunks equal on the last chunk (index N-1): set eq=1, go to DONE.
REQ-020 Chunks equal otherwise: shift both operands left by CHUNK, increment the index, stay in RUN.
REQ-021 DONE: done=1 for exactly one cycle, then IDLE unconditionally.
REQ-022 Latency: first difference in chunk j (0 = MSB) gives done high in cycle j+1 after the accepting edge; equal operands give cycle N.
REQ-023 Exactly one of eq/lt/gt is high from done until the next accepted start; the result is held while idle.
REQ-024 start while busy=1 (RUN or DONE), including the done cycle, is ignored and has no effect on operands or result.
REQ-025 Changes on first_word/second_word/signed_mode after acceptance do not affect the result.
REQ-026 A new start accepted in IDLE clears the held result at that edge.

Reset
REQ-027 rst=1 at an edge: state=IDLE, busy=0, done=0, eq=0, lt=0, gt=0, index=0; rst has priority over start.
REQ-028 Reset mid-RUN or in DONE aborts the comparison; no done pulse is produced for the aborted request.

Structure
REQ-029 Package comparator_pkg holds the state enum typedef (IDLE/RUN/DONE).
REQ-030 One combinational sub-module, chunk_magnitude_cmp, parametrised by CHUNK, with outputs eq/lt/gt for one chunk pair; comparator_serial instantiates it once.
REQ-031 The index counter width is $clog2(N), minimum 1.

Verification (WIDTH=8, CHUNK=2, N=4)
REQ-032 A=0x5A, B=0x5A, unsigned -> done in cycle 4, eq=1, lt=gt=0; busy high in cycles 1-4.
REQ-033 A=0x80, B=0x7F, unsigned -> done in cycle 1, gt=1; same operands with signed_mode=1 -> done in cycle 1, lt=1.
REQ-034 A=0x12, B=0x13, unsigned -> done in cycle 4, lt=1; A=0xFF, B=0xFE, signed -> done in cycle 4, gt=1.
REQ-035 Start accepted, operands changed and start pulsed in cycles 1-3 -> original result delivered, single done pulse.
REQ-036 rst asserted in cycle 2 of a RUN -> next cycle busy=0, done=0, eq/lt/gt=0; no done pulse follows.
REQ-037 Back-to-back: start held high continuously -> accepted only in IDLE, one done per request, result cleared at each acceptance.

Source files
------------

// File: rtl/comparator_pkg.sv
// comparator_pkg
// Shared declarations for the serial magnitude comparator.
//   state_t     : FSM state encoding (IDLE / RUN / DONE)
//   index_width : width of the chunk index counter, never below one bit
package comparator_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Counter width for n chunks; a single chunk still needs a one-bit index.
    function automatic int index_width(input int n);
        int w;
        w = $clog2(n);
        if (w < 1) begin
            w = 1;
        end else begin
            w = w;
        end
        return w;
    endfunction

endpackage

// File: rtl/chunk_magnitude_cmp.sv
// chunk_magnitude_cmp
// Purely combinational unsigned magnitude compare of one CHUNK-bit slice.
// Ports:
//   a, b : CHUNK-bit unsigned slices (a from operand A, b from operand B)
//   eq   : a == b
//   lt   : a <  b
//   gt   : a >  b
// Exactly one of eq/lt/gt is high for any input pair.
module chunk_magnitude_cmp #(
    parameter int CHUNK = 2
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    output logic             eq,
    output logic             lt,
    output logic             gt
);

    // Three-way decision on the slice pair.
    always_comb begin
        eq = 1'b0;
        lt = 1'b0;
        gt = 1'b0;
        if (a == b) begin
            eq = 1'b1;
        end else if (a < b) begin
            lt = 1'b1;
        end else begin
            gt = 1'b1;
        end
    end

endmodule

// File: rtl/comparator_serial.sv
// comparator_serial
// Multi-cycle magnitude comparator that walks the operands MSB-first, CHUNK
// bits per clock, and stops on the first differing chunk.
// Ports:
//   clk         : clock, all state changes on the rising edge
//   rst         : synchronous active-high reset, has priority over start
//   start       : compare request, accepted only while busy is low
//   signed_mode : 1 = two's-complement compare, 0 = unsigned (sampled on accept)
//   first_word  : operand A (sampled on accept)
//   second_word : operand B (sampled on accept)
//   busy        : high whenever the FSM is not IDLE
//   done        : one-cycle pulse marking a valid result
//   eq, lt, gt  : A == B, A < B, A > B; held until the next accepted start
module comparator_serial
    import comparator_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CHUNK = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             signed_mode,
    input  logic [WIDTH-1:0] first_word,
    input  logic [WIDTH-1:0] second_word,
    output logic             busy,
    output logic             done,
    output logic             eq,
    output logic             lt,
    output logic             gt
);

    localparam int N    = WIDTH / CHUNK;
    localparam int IDXW = index_width(N);
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(N - 1);
    localparam logic [IDXW-1:0] IDX_ONE  = IDXW'(1);

    state_t             state_r;
    state_t             state_s;
    logic [WIDTH-1:0]   a_r;
    logic [WIDTH-1:0]   a_s;
    logic [WIDTH-1:0]   b_r;
    logic [WIDTH-1:0]   b_s;
    logic [IDXW-1:0]    idx_r;
    logic [IDXW-1:0]    idx_s;
    logic               eq_r;
    logic               eq_s;
    logic               lt_r;
    logic               lt_s;
    logic               gt_r;
    logic               gt_s;
    logic               done_r;
    logic               busy_r;
    logic               chunk_eq_s;
    logic               chunk_lt_s;
    logic               chunk_gt_s;

    // Flipping the sign bit maps two's-complement order onto unsigned order,
    // so the datapath only ever needs an unsigned compare.
    function automatic logic [WIDTH-1:0] bias_operand(input logic [WIDTH-1:0] w,
                                                      input logic             is_signed);
        logic [WIDTH-1:0] r;
        r = w;
        if (is_signed) begin
            r[WIDTH-1] = ~w[WIDTH-1];
        end else begin
            r[WIDTH-1] = w[WIDTH-1];
        end
        return r;
    endfunction

    // The operands are shifted left after each equal chunk, so the chunk under
    // test is always the top CHUNK bits of the shift registers.
    chunk_magnitude_cmp #(
        .CHUNK (CHUNK)
    ) u_chunk_cmp (
        .a  (a_r[WIDTH-1 -: CHUNK]),
        .b  (b_r[WIDTH-1 -: CHUNK]),
        .eq (chunk_eq_s),
        .lt (chunk_lt_s),
        .gt (chunk_gt_s)
    );

    // Next-state and next-datapath decode.
    always_comb begin
        state_s = state_r;
        a_s     = a_r;
        b_s     = b_r;
        idx_s   = idx_r;
        eq_s    = eq_r;
        lt_s    = lt_r;
        gt_s    = gt_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    a_s     = bias_operand(first_word, signed_mode);
                    b_s     = bias_operand(second_word, signed_mode);
                    idx_s   = {IDXW{1'b0}};
                    eq_s    = 1'b0;
                    lt_s    = 1'b0;
                    gt_s    = 1'b0;
                    state_s = RUN;
                end else begin
                    state_s = IDLE;
                end
            end
            RUN: begin
                if (!chunk_eq_s) begin
                    // First differing chunk decides the whole compare.
                    eq_s    = 1'b0;
                    lt_s    = chunk_lt_s;
                    gt_s    = chunk_gt_s;
                    state_s = DONE;
                end else if (idx_r == LAST_IDX) begin
                    eq_s    = 1'b1;
                    lt_s    = 1'b0;
                    gt_s    = 1'b0;
                    state_s = DONE;
                end else begin
                    a_s     = a_r << CHUNK;
                    b_s     = b_r << CHUNK;
                    idx_s   = idx_r + IDX_ONE;
                    state_s = RUN;
                end
            end
            DONE: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State, datapath and registered status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            a_r     <= {WIDTH{1'b0}};
            b_r     <= {WIDTH{1'b0}};
            idx_r   <= {IDXW{1'b0}};
            eq_r    <= 1'b0;
            lt_r    <= 1'b0;
            gt_r    <= 1'b0;
            done_r  <= 1'b0;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            a_r     <= a_s;
            b_r     <= b_s;
            idx_r   <= idx_s;
            eq_r    <= eq_s;
            lt_r    <= lt_s;
            gt_r    <= gt_s;
            // done and busy track the state being entered, so they line up
            // exactly with the DONE / non-IDLE cycles without extra decode.
            done_r  <= (state_s == DONE);
            busy_r  <= (state_s != IDLE);
        end
    end

    assign busy = busy_r;
    assign done = done_r;
    assign eq   = eq_r;
    assign lt   = lt_r;
    assign gt   = gt_r;

endmodule

// File: tb/tb_comparator_serial.sv
// Directed self-checking bench for comparator_serial (WIDTH=8, CHUNK=2).
module tb_comparator_serial;

    logic       clk;
    logic       rst;
    logic       start;
    logic       signed_mode;
    logic [7:0] first_word;
    logic [7:0] second_word;
    logic       busy;
    logic       done;
    logic       eq;
    logic       lt;
    logic       gt;

    int vectors;
    int miscompares;

    comparator_serial #(
        .WIDTH (8),
        .CHUNK (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .signed_mode (signed_mode),
        .first_word  (first_word),
        .second_word (second_word),
        .busy        (busy),
        .done        (done),
        .eq          (eq),
        .lt          (lt),
        .gt          (gt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_res(input string tag, input logic e, input logic l, input logic g);
        chk({tag, ".eq"}, {7'd0, eq}, {7'd0, e});
        chk({tag, ".lt"}, {7'd0, lt}, {7'd0, l});
        chk({tag, ".gt"}, {7'd0, gt}, {7'd0, g});
    endtask

    // One full request: accept, lat-1 RUN cycles, done pulse, back in IDLE.
    task automatic run_cmp(input string tag, input logic [7:0] a, input logic [7:0] b,
                           input logic sm, input int lat,
                           input logic e, input logic l, input logic g);
        first_word  = a;
        second_word = b;
        signed_mode = sm;
        start       = 1'b1;
        tick();
        start = 1'b0;
        chk({tag, ".acc_busy"}, {7'd0, busy}, 8'd1);
        chk_res({tag, ".cleared"}, 1'b0, 1'b0, 1'b0);
        for (int k = 1; k <= lat; k++) begin
            tick();
            chk({tag, ".busy"}, {7'd0, busy}, 8'd1);
            chk({tag, ".done"}, {7'd0, done}, (k == lat) ? 8'd1 : 8'd0);
        end
        chk_res({tag, ".res"}, e, l, g);
        tick();
        chk({tag, ".idle_done"}, {7'd0, done}, 8'd0);
        chk({tag, ".idle_busy"}, {7'd0, busy}, 8'd0);
        chk_res({tag, ".held"}, e, l, g);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b1;
        start       = 1'b1;
        signed_mode = 1'b0;
        first_word  = 8'h00;
        second_word = 8'h00;

        // Reset with start high: reset must win.
        tick();
        tick();
        chk("rst.busy", {7'd0, busy}, 8'd0);
        chk("rst.done", {7'd0, done}, 8'd0);
        chk_res("rst", 1'b0, 1'b0, 1'b0);
        start = 1'b0;
        rst   = 1'b0;
        tick();

        // Directed vectors with hand-derived latencies (chunk index + 1).
        run_cmp("eq5a",  8'h5A, 8'h5A, 1'b0, 4, 1'b1, 1'b0, 1'b0);
        run_cmp("u80",   8'h80, 8'h7F, 1'b0, 1, 1'b0, 1'b0, 1'b1);
        run_cmp("s80",   8'h80, 8'h7F, 1'b1, 1, 1'b0, 1'b1, 1'b0);
        run_cmp("u12",   8'h12, 8'h13, 1'b0, 4, 1'b0, 1'b1, 1'b0);
        run_cmp("sff",   8'hFF, 8'hFE, 1'b1, 4, 1'b0, 1'b0, 1'b1);
        run_cmp("u34",   8'h34, 8'h24, 1'b0, 2, 1'b0, 1'b0, 1'b1);
        run_cmp("s01",   8'h01, 8'hFF, 1'b1, 1, 1'b0, 1'b0, 1'b1);
        run_cmp("u01",   8'h01, 8'hFF, 1'b0, 1, 1'b0, 1'b1, 1'b0);

        // Inputs disturbed and start pulsed while busy.
        first_word  = 8'h12;
        second_word = 8'h13;
        signed_mode = 1'b0;
        start       = 1'b1;
        tick();
        first_word  = 8'hFF;
        second_word = 8'h00;
        signed_mode = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            tick();
            chk("dist.done", {7'd0, done}, 8'd0);
            chk("dist.busy", {7'd0, busy}, 8'd1);
        end
        start = 1'b0;
        tick();
        chk("dist.done4", {7'd0, done}, 8'd1);
        chk_res("dist", 1'b0, 1'b1, 1'b0);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("dist.nodone", {7'd0, done}, 8'd0);
            chk("dist.idle", {7'd0, busy}, 8'd0);
        end
        chk_res("dist.held", 1'b0, 1'b1, 1'b0);

        // Reset in the middle of a RUN aborts the request.
        first_word  = 8'h5A;
        second_word = 8'h5A;
        signed_mode = 1'b0;
        start       = 1'b1;
        tick();
        start = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort.busy", {7'd0, busy}, 8'd0);
        chk("abort.done", {7'd0, done}, 8'd0);
        chk_res("abort", 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("abort.nodone", {7'd0, done}, 8'd0);
            chk("abort.idle", {7'd0, busy}, 8'd0);
        end

        // Start held high: accepted only from IDLE, result cleared per accept.
        first_word  = 8'h80;
        second_word = 8'h7F;
        signed_mode = 1'b0;
        start       = 1'b1;
        tick();
        chk("b2b.acc1", {7'd0, busy}, 8'd1);
        tick();
        chk("b2b.done1", {7'd0, done}, 8'd1);
        chk_res("b2b.r1", 1'b0, 1'b0, 1'b1);
        signed_mode = 1'b1;
        tick();
        chk("b2b.idle_done", {7'd0, done}, 8'd0);
        chk("b2b.idle_busy", {7'd0, busy}, 8'd0);
        chk_res("b2b.held", 1'b0, 1'b0, 1'b1);
        tick();
        chk("b2b.acc2", {7'd0, busy}, 8'd1);
        chk("b2b.acc2_done", {7'd0, done}, 8'd0);
        chk_res("b2b.clr", 1'b0, 1'b0, 1'b0);
        tick();
        start = 1'b0;
        chk("b2b.done2", {7'd0, done}, 8'd1);
        chk_res("b2b.r2", 1'b0, 1'b1, 1'b0);
        tick();
        chk("b2b.end_done", {7'd0, done}, 8'd0);
        chk("b2b.end_busy", {7'd0, busy}, 8'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
